// File: rtl/capture_pkg.sv
// capture_pkg: state encoding and trigger source bit positions shared by the capture controller
package capture_pkg;

    typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POSTTRIG, DONE} cap_state_t;

    localparam int TRIG_UART = 0;
    localparam int TRIG_SPI  = 1;
    localparam int TRIG_CHAN = 2;

endpackage

// File: rtl/cap_addr_cnt.sv
// cap_addr_cnt: wrapping sample RAM write pointer with clear and increment
module cap_addr_cnt #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] addr_o
);

    logic [W-1:0] addr_q, addr_d;

    assign addr_d = clr_i ? '0 : inc_i ? addr_q + 1'b1 : addr_q;
    assign addr_o = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences the sample RAM write pointer through pre-trigger fill,
// armed, post-trigger and done phases from qualified UART/SPI/channel triggers
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              sample_en,
    input  logic              UARTtrig,
    input  logic              SPItrig,
    input  logic              chan_trig,
    input  logic [2:0]        trig_src_en,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done
);

    cap_state_t        state_q, state_d;
    logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d, pre_lim;
    logic [ADDR_W-1:0] tp_q, tp_d, trig_addr_q, trig_addr_d;
    logic              triggered_q, triggered_d, armed_q, done_q;
    logic [2:0]        trig_vec;
    logic              trig_hit, take_trig;

    assign trig_vec[TRIG_UART] = UARTtrig;
    assign trig_vec[TRIG_SPI]  = SPItrig;
    assign trig_vec[TRIG_CHAN] = chan_trig;
    assign trig_hit  = |(trig_vec & trig_src_en);
    assign take_trig = state_q == ARMED && run && trig_hit;
    // DEPTH - tp, one bit wider so tp=0 yields a full buffer of pre-trigger samples
    assign pre_lim   = {1'b1, {ADDR_W{1'b0}}} - {1'b0, tp_q};

    assign we = sample_en && (state_q == PRETRIG || state_q == ARMED || state_q == POSTTRIG)
                && !(take_trig && tp_q == '0);

    cap_addr_cnt #(.W(ADDR_W)) u_addr (
        .clk    (clk),
        .rst    (rst_n),
        .clr_i  (state_q == IDLE),
        .inc_i  (we),
        .addr_o (waddr)
    );

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        tp_d        = tp_q;
        triggered_d = triggered_q;
        trig_addr_d = trig_addr_q;
        case (state_q)
            IDLE: begin
                pre_cnt_d   = '0;
                post_cnt_d  = '0;
                triggered_d = 1'b0;
                tp_d        = trig_pos;
                if (run) state_d = PRETRIG;
            end
            PRETRIG: begin
                if (!run) begin
                    state_d     = IDLE;
                    triggered_d = 1'b0;
                end else if (we) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_d == pre_lim) state_d = ARMED;
                end
            end
            ARMED: begin
                if (!run) begin
                    state_d     = IDLE;
                    triggered_d = 1'b0;
                end else if (trig_hit) begin
                    triggered_d = 1'b1;
                    trig_addr_d = waddr;
                    post_cnt_d  = {{ADDR_W{1'b0}}, we};
                    state_d     = post_cnt_d == {1'b0, tp_q} ? DONE : POSTTRIG;
                end
            end
            POSTTRIG: begin
                if (!run) begin
                    state_d     = IDLE;
                    triggered_d = 1'b0;
                end else if (we) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == {1'b0, tp_q}) state_d = DONE;
                end
            end
            DONE: begin
                if (clr_done) begin
                    state_d     = IDLE;
                    triggered_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            tp_q        <= '0;
            triggered_q <= 1'b0;
            trig_addr_q <= '0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            tp_q        <= tp_d;
            triggered_q <= triggered_d;
            trig_addr_q <= trig_addr_d;
            armed_q     <= state_d == ARMED;
            done_q      <= state_d == DONE;
        end
    end

    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign trig_addr    = trig_addr_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven capture scenarios, hand-written corner sequences and a
// randomized run, all checked every cycle against a countdown-based reference model
module tb_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 0, rst_n = 1, run = 0, sample_en = 0, clr_done = 0;
    logic          UARTtrig = 0, SPItrig = 0, chan_trig = 0;
    logic [2:0]    trig_src_en = 0;
    logic [AW-1:0] trig_pos = 0;
    logic          we, armed, triggered, capture_done;
    logic [AW-1:0] waddr, trig_addr;

    capture_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .sample_en(sample_en),
        .UARTtrig(UARTtrig), .SPItrig(SPItrig), .chan_trig(chan_trig),
        .trig_src_en(trig_src_en), .trig_pos(trig_pos), .clr_done(clr_done),
        .we(we), .waddr(waddr), .armed(armed), .triggered(triggered),
        .trig_addr(trig_addr), .capture_done(capture_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc_n = 0;
    bit alt = 1;

    // phase: 0 idle, 1 filling history, 2 waiting for trigger, 3 collecting post samples, 4 finished
    int m_ph, m_addr, m_need, m_left, m_tp, m_taddr;
    bit m_trig, m_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit hit();
        return |({chan_trig, SPItrig, UARTtrig} & trig_src_en);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_addr = 0; m_need = 0; m_left = 0; m_tp = 0; m_taddr = 0; m_trig = 0;
    endtask

    task automatic model_seq();
        int old;
        if (rst_n) begin
            model_reset();
            return;
        end
        old = m_addr;
        if (m_we) m_addr = (m_addr + 1) % DEPTH;
        case (m_ph)
            0: begin
                m_addr = 0;
                m_trig = 0;
                if (run) begin
                    m_ph = 1; m_tp = int'(trig_pos); m_need = DEPTH - m_tp;
                end
            end
            1: if (!run) begin m_ph = 0; m_trig = 0; end
               else if (m_we) begin m_need--; if (m_need == 0) m_ph = 2; end
            2: if (!run) begin m_ph = 0; m_trig = 0; end
               else if (hit()) begin
                   m_trig = 1; m_taddr = old; m_left = m_tp - int'(m_we);
                   m_ph = m_left == 0 ? 4 : 3;
               end
            3: if (!run) begin m_ph = 0; m_trig = 0; end
               else if (m_we) begin m_left--; if (m_left == 0) m_ph = 4; end
            default: if (clr_done) begin m_ph = 0; m_trig = 0; end
        endcase
    endtask

    task automatic tick();
        if (alt) sample_en = cyc_n[0];
        cyc_n++;
        #2;
        m_we = sample_en && m_ph >= 1 && m_ph <= 3 && !(m_ph == 2 && run && hit() && m_tp == 0);
        chk("we", we, m_we);
        @(posedge clk);
        model_seq();
        #1;
        chk("armed", armed, m_ph == 2);
        chk("capture_done", capture_done, m_ph == 4);
        chk("triggered", triggered, m_trig);
        chk("trig_addr", trig_addr, m_taddr);
        chk("waddr", waddr, m_addr);
    endtask

    task automatic pulse(input logic [2:0] p);
        {chan_trig, SPItrig, UARTtrig} = p;
        tick();
        {chan_trig, SPItrig, UARTtrig} = 3'b000;
    endtask

    function automatic bit cond(input int w, input int t);
        return w == 0 ? armed === 1'b1 : w == 1 ? (armed === 1'b1 && int'(waddr) == t)
                                                : capture_done === 1'b1;
    endfunction

    task automatic wait_for(input string nm, input int w, input int t, input int budget);
        int n = 0;
        while (!cond(w, t) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, " reached"}, cond(w, t), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " we"}, we, 0);
        chk({nm, " waddr"}, waddr, 0);
        chk({nm, " armed"}, armed, 0);
        chk({nm, " triggered"}, triggered, 0);
        chk({nm, " trig_addr"}, trig_addr, 0);
        chk({nm, " capture_done"}, capture_done, 0);
    endtask

    typedef struct {
        int         tp;
        logic [2:0] en, early, bad, good;
        int         at, exp_taddr, exp_waddr;
    } vec_t;

    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{tp: 4,  en: 3'b001, early: 3'b001, bad: 3'b110, good: 3'b001, at: 5,  exp_taddr: 5,  exp_waddr: 9};
        vt[1] = '{tp: 0,  en: 3'b111, early: 3'b000, bad: 3'b000, good: 3'b100, at: 3,  exp_taddr: 3,  exp_waddr: 3};
        vt[2] = '{tp: 15, en: 3'b010, early: 3'b010, bad: 3'b101, good: 3'b010, at: 2,  exp_taddr: 2,  exp_waddr: 1};
        vt[3] = '{tp: 1,  en: 3'b100, early: 3'b100, bad: 3'b011, good: 3'b100, at: 14, exp_taddr: 14, exp_waddr: 15};
        vt[4] = '{tp: 8,  en: 3'b111, early: 3'b000, bad: 3'b000, good: 3'b010, at: 0,  exp_taddr: 0,  exp_waddr: 8};

        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 0;

        for (int i = 0; i < 5; i++) begin
            trig_pos = AW'(vt[i].tp);
            trig_src_en = vt[i].en;
            run = 1;
            tick();
            pulse(vt[i].early);
            wait_for("armed", 0, 0, 200);
            pulse(vt[i].bad);
            chk("disabled source ignored", armed, 1);
            wait_for("trigger point", 1, vt[i].at, 100);
            pulse(vt[i].good);
            wait_for("done", 2, 0, 100);
            chk("row trig_addr", trig_addr, vt[i].exp_taddr);
            chk("row final waddr", waddr, vt[i].exp_waddr);
            chk("row triggered", triggered, 1);
            run = 0;
            tick();
            tick();
            chk("done holds with run low", capture_done, 1);
            clr_done = 1;
            tick();
            clr_done = 0;
            chk("clr armed", armed, 0);
            chk("clr triggered", triggered, 0);
            chk("clr done", capture_done, 0);
        end

        // long armed phase with wrap, then abort during post-trigger collection
        trig_pos = 4;
        trig_src_en = 3'b001;
        run = 1;
        tick();
        wait_for("wrap armed", 0, 0, 200);
        chk("armed after 12 writes", waddr, 12);
        repeat (80) tick();
        chk("wrap waddr", waddr, 4);
        chk("wrap still armed", armed, 1);
        pulse(3'b001);
        tick();
        chk("posttrig triggered", triggered, 1);
        chk("posttrig not armed", armed, 0);
        run = 0;
        tick();
        chk("abort triggered", triggered, 0);
        chk("abort done", capture_done, 0);
        chk("abort armed", armed, 0);

        // asynchronous reset in the middle of post-trigger collection
        run = 1;
        tick();
        wait_for("reset armed", 0, 0, 200);
        pulse(3'b001);
        tick();
        chk("pre-reset triggered", triggered, 1);
        #2;
        rst_n = 1;
        model_reset();
        #1;
        chk_all_zero("async reset");
        tick();
        rst_n = 0;
        run = 0;
        tick();
        chk_all_zero("after release");

        alt = 0;
        trig_src_en = 3'b111;
        for (int i = 0; i < 3000; i++) begin
            sample_en = ($urandom % 2) == 1;
            UARTtrig  = ($urandom % 6) == 0;
            SPItrig   = ($urandom % 6) == 0;
            chan_trig = ($urandom % 6) == 0;
            if ($urandom % 40 == 0) trig_src_en = 3'($urandom);
            trig_pos = AW'($urandom);
            run = ($urandom % 120) != 0;
            clr_done = ($urandom % 10) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
